sdram_wr_burst_ctrl: RTL and testbench

- Sits directly downstream of the write-side async FIFO, in the SDRAM clock domain. Drains the FIFO read port.
- Waits until the FIFO holds a full burst, then requests a write burst from the SDRAM command controller.
- Streams FIFO words to the controller on its per-word data requests and advances a wrapping write address after every completed burst.

---
 rtl/sdram_wr_burst_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sdram_wr_burst_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_burst_ctrl.sv
// Write-burst controller: drains the write FIFO into fixed-length SDRAM write bursts on a wrapping address ring.
// Define WR_PARTIAL_FLUSH_EN to flush a sub-burst FIFO residue after TIMEOUT idle cycles.
module sdram_wr_burst_ctrl #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_RANGE = 32'h10000,
  parameter int unsigned NUM_W      = 128
`ifdef WR_PARTIAL_FLUSH_EN
  ,
  parameter int unsigned TIMEOUT    = 1024
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [NUM_W-1:0]  fifo_data_num,
  output logic              fifo_rd_en,
  input  logic [15:0]       fifo_rd_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_burst_len,
  input  logic              wr_data_req,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic              underrun_err
);

  localparam int unsigned LEN_W = 9;
  localparam int unsigned AW1   = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One bit wider than the address so a ring ending at 2**ADDR_W still compares correctly.
  localparam logic [AW1-1:0] ADDR_END = AW1'(ADDR_BASE) + AW1'(ADDR_RANGE);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [AW1-1:0]    w_addr_inc;
  logic              r_underrun;
  logic              w_underrun_nxt;
  logic              r_wr_req;
  logic              r_busy;
  logic              r_burst_done;
  logic              w_start_full;

  assign w_start_full = enable && (fifo_data_num >= NUM_W'(BURST_LEN));
  assign w_addr_inc   = AW1'(r_addr) + AW1'(BURST_LEN);

`ifdef WR_PARTIAL_FLUSH_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_idle_cnt;
  logic             w_idle_cond;
  logic             w_flush;

  assign w_idle_cond = (r_state == S_IDLE) && enable && !fifo_empty &&
                       (fifo_data_num < NUM_W'(BURST_LEN));
  assign w_flush     = w_idle_cond && (r_idle_cnt == TMO_W'(TIMEOUT - 1));

  // Counts consecutive idle cycles with a stranded partial burst in the FIFO.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_idle_cond && !w_flush) begin
      r_idle_cnt <= r_idle_cnt + TMO_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end
`endif

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_len_nxt      = r_len;
    w_addr_nxt     = r_addr;
    w_underrun_nxt = r_underrun;
    case (r_state)
      S_IDLE: begin
        if (w_start_full) begin
          w_state_nxt = S_REQ;
          w_len_nxt   = LEN_W'(BURST_LEN);
        end
`ifdef WR_PARTIAL_FLUSH_EN
        else if (w_flush) begin
          w_state_nxt = S_REQ;
          w_len_nxt   = LEN_W'(fifo_data_num);
        end
`endif
      end
      S_REQ: begin
        if (wr_ack) begin
          w_state_nxt = S_BURST;
          w_cnt_nxt   = '0;
        end
      end
      S_BURST: begin
        // An empty FIFO still consumes a word slot so the controller's burst length holds.
        if (wr_data_req) begin
          w_cnt_nxt = r_cnt + LEN_W'(1);
          if (fifo_empty) begin
            w_underrun_nxt = 1'b1;
          end
          if (r_cnt == r_len - LEN_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = (w_addr_inc == ADDR_END) ? ADDR_W'(ADDR_BASE) : w_addr_inc[ADDR_W-1:0];
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_addr       <= ADDR_W'(ADDR_BASE);
      r_underrun   <= 1'b0;
      r_wr_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_addr       <= w_addr_nxt;
      r_underrun   <= w_underrun_nxt;
      r_wr_req     <= (w_state_nxt == S_REQ);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_burst_done <= (w_state_nxt == S_DONE);
    end
  end

  assign fifo_rd_en   = (r_state == S_BURST) && wr_data_req && !fifo_empty;
  assign wr_data      = fifo_rd_data;
  assign wr_req       = r_wr_req;
  assign wr_addr      = r_addr;
  assign wr_burst_len = r_len;
  assign busy         = r_busy;
  assign burst_done   = r_burst_done;
  assign underrun_err = r_underrun;

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Bench for sdram_wr_burst_ctrl: directed scenarios then randomized traffic, all checked
// every cycle against a transaction-level model of bursts, words left and ring address.
module tb_sdram_wr_burst_ctrl;

  localparam int BL    = 8;
  localparam int BASE  = 0;
  localparam int RANGE = 16;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         enable;
  logic         fifo_empty;
  logic [127:0] fifo_data_num;
  logic         fifo_rd_en;
  logic [15:0]  fifo_rd_data = '0;
  logic         wr_req;
  logic         wr_ack;
  logic [23:0]  wr_addr;
  logic [8:0]   wr_burst_len;
  logic         wr_data_req;
  logic [15:0]  wr_data;
  logic         busy;
  logic         burst_done;
  logic         underrun_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_pulses = 0;

  sdram_wr_burst_ctrl #(
    .BURST_LEN (BL),
    .ADDR_W    (24),
    .ADDR_BASE (BASE),
    .ADDR_RANGE(RANGE),
    .NUM_W     (128)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data_num(fifo_data_num),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .wr_addr      (wr_addr),
    .wr_burst_len (wr_burst_len),
    .wr_data_req  (wr_data_req),
    .wr_data      (wr_data),
    .busy         (busy),
    .burst_done   (burst_done),
    .underrun_err (underrun_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // FIFO stand-in: k-th word popped is 0x1000+k, presented one cycle after the strobe.
  int f_seq = 0;
  always @(posedge sys_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= 16'h1000 + 16'(f_seq);
      f_seq        <= f_seq + 1;
    end
  end

  // Model: phase 0 idle, 1 requesting, 2 streaming (m_left words to go), 3 finishing.
  int          m_phase;
  int          m_left;
  int          m_addr;
  int          m_len;
  logic        m_und;
  logic        m_rd_pend;
  logic [15:0] m_word;
  int          m_rd_cnt = 0;
  logic        exp_rd_en;

  assign exp_rd_en = (m_phase == 2) && wr_data_req && !fifo_empty;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_phase   <= 0;
      m_left    <= 0;
      m_addr    <= BASE;
      m_len     <= 0;
      m_und     <= 1'b0;
      m_rd_pend <= 1'b0;
    end else begin
      m_rd_pend <= exp_rd_en;
      if (exp_rd_en) begin
        m_word   <= 16'h1000 + 16'(m_rd_cnt);
        m_rd_cnt <= m_rd_cnt + 1;
      end
      case (m_phase)
        0: if (enable && fifo_data_num >= 128'd8) begin
             m_phase <= 1;
             m_len   <= BL;
           end
        1: if (wr_ack) begin
             m_phase <= 2;
             m_left  <= m_len;
           end
        2: if (wr_data_req) begin
             if (fifo_empty) m_und <= 1'b1;
             m_left <= m_left - 1;
             if (m_left == 1) m_phase <= 3;
           end
        default: begin
          m_phase <= 0;
          m_addr  <= BASE + (m_addr - BASE + BL) % RANGE;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk("wr_req", 32'(wr_req), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("burst_done", 32'(burst_done), 32'(m_phase == 3));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_burst_len", 32'(wr_burst_len), 32'(m_len));
    chk("underrun_err", 32'(underrun_err), 32'(m_und));
    if (burst_done) done_cnt++;
  endtask

  task automatic check_comb();
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd_en));
    if (fifo_rd_en) rd_pulses++;
    if (m_rd_pend) chk("wr_data", 32'(wr_data), 32'(m_word));
  endtask

  task automatic drive(input logic en, input logic emp, input logic [127:0] num,
                       input logic ack, input logic dreq);
    enable        = en;
    fifo_empty    = emp;
    fifo_data_num = num;
    wr_ack        = ack;
    wr_data_req   = dreq;
    #1;
    check_comb();
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_regs();
  endtask

  task automatic cyc(input logic en, input logic emp, input logic [127:0] num,
                     input logic ack, input logic dreq);
    drive(en, emp, num, ack, dreq);
    tick();
  endtask

  initial begin
    logic [127:0] big;
    sys_rst_n     = 1'b0;
    enable        = 1'b0;
    fifo_empty    = 1'b1;
    fifo_data_num = '0;
    wr_ack        = 1'b0;
    wr_data_req   = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_len", 32'(wr_burst_len), 32'd0);
    chk("rst_underrun", 32'(underrun_err), 32'd0);
    check_regs();
    sys_rst_n = 1'b1;

    // Seven words never start a burst; the eighth does on the next cycle.
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 128'd7, 1'b0, 1'b0);
    chk("gate_no_req", 32'(wr_req), 32'd0);
    cyc(1'b1, 1'b0, 128'd8, 1'b0, 1'b0);
    chk("gate_req", 32'(wr_req), 32'd1);
    chk("gate_addr", 32'(wr_addr), 32'd0);
    chk("gate_len", 32'(wr_burst_len), 32'd8);

    // Single burst with contiguous word requests.
    cyc(1'b1, 1'b0, 128'd8, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 128'd8, 1'b1, 1'b0);
    for (int i = 0; i < BL; i++) cyc(1'b1, 1'b0, 128'd8, 1'b0, 1'b1);
    chk("b1_last_word", 32'(wr_data), 32'h1007);
    chk("b1_done", 32'(burst_done), 32'd1);
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    chk("b1_addr", 32'(wr_addr), 32'd8);
    chk("b1_done_cnt", 32'(done_cnt), 32'd1);

    // Gapped requests, enable dropped while waiting for the grant, stray acks in BURST.
    cyc(1'b1, 1'b0, 128'd200, 1'b0, 1'b0);
    chk("b2_req", 32'(wr_req), 32'd1);
    chk("b2_addr", 32'(wr_addr), 32'd8);
    repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
    rd_pulses = 0;
    for (int i = 0; i < BL; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b1, 1'b0, 128'd3, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 128'd3, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    chk("b2_reads", 32'(rd_pulses), 32'd8);
    chk("b2_wrap_addr", 32'(wr_addr), 32'd0);
    chk("b2_done_cnt", 32'(done_cnt), 32'd2);

    // Top bit alone of the fill count starts a burst; underrun on the 5th word, then reset.
    big = '0;
    big[127] = 1'b1;
    cyc(1'b1, 1'b0, big, 1'b0, 1'b0);
    chk("b3_req", 32'(wr_req), 32'd1);
    chk("b3_addr", 32'(wr_addr), 32'd0);
    cyc(1'b1, 1'b0, 128'd8, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 128'd8, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 128'd8, 1'b0, 1'b1);
    chk("ur_no_rd", 32'(fifo_rd_en), 32'd0);
    tick();
    chk("ur_flag", 32'(underrun_err), 32'd1);
    cyc(1'b1, 1'b0, 128'd8, 1'b0, 1'b1);
    chk("ur_still_busy", 32'(busy), 32'd1);
    enable = 1'b1; fifo_empty = 1'b0; wr_data_req = 1'b1; fifo_data_num = 128'd8;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mrst_wr_req", 32'(wr_req), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(burst_done), 32'd0);
    chk("mrst_underrun", 32'(underrun_err), 32'd0);
    chk("mrst_addr", 32'(wr_addr), 32'd0);
    chk("mrst_len", 32'(wr_burst_len), 32'd0);
    chk("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_regs();
    sys_rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] num;
      int r;
      r = $urandom_range(0, 15);
      if (r < 12) num = 128'(r);
      else        num = {$urandom, 96'd0};
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), num,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
